// File: rtl/spi_master.sv
// SPI master: one DATA_WIDTH word per transaction, all four SPI modes, Start/Busy/Done handshake.
// Optional SPIMASTER_LSBFIRST_EN adds a LsbFirst input selecting bit-0-first transfers.
module spi_master #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic [1:0]            Mode,
  input  logic [DATA_WIDTH-1:0] DataWr,
`ifdef SPIMASTER_LSBFIRST_EN
  input  logic                  LsbFirst,
`endif
  output logic [DATA_WIDTH-1:0] DataRd,
  output logic                  Busy,
  output logic                  Done,
  output logic                  SCK,
  output logic                  SDO,
  input  logic                  SDI,
  output logic                  CS
);

  localparam int unsigned CntW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned EdgeW = $clog2(2 * DATA_WIDTH);
  localparam logic [CntW-1:0]  CntLast  = CntW'(CLK_DIV - 1);
  localparam logic [EdgeW-1:0] EdgeLast = EdgeW'(2 * DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic [EdgeW-1:0]        edge_q;
  logic                    cpha_q;
  logic                    lsb_q;
  logic [DATA_WIDTH-1:0]   tx_q;
  logic [DATA_WIDTH-1:0]   rx_q;
  logic                    lsb_in;
  logic [DATA_WIDTH-1:0]   tx_load;
  logic [DATA_WIDTH-1:0]   rx_next;

`ifdef SPIMASTER_LSBFIRST_EN
  assign lsb_in = LsbFirst;
`else
  assign lsb_in = 1'b0;
`endif

  // The transmit shifter always runs MSB-first; LSB-first order is a bit-reversed load.
  always_comb begin
    tx_load = DataWr;
    if (lsb_in) begin
      for (int i = 0; i < int'(DATA_WIDTH); i++) begin
        tx_load[i] = DataWr[DATA_WIDTH-1-i];
      end
    end
  end

  always_comb begin
    rx_next = lsb_q ? {SDI, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], SDI};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      edge_q  <= '0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      DataRd  <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      SCK     <= 1'b0;
      SDO     <= 1'b0;
      CS      <= 1'b1;
    end else begin
      Done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          CS   <= 1'b1;
          SDO  <= 1'b0;
          Busy <= 1'b0;
          SCK  <= Mode[1];
          if (Start) begin
            cpha_q  <= Mode[0];
            lsb_q   <= lsb_in;
            tx_q    <= tx_load;
            SDO     <= tx_load[DATA_WIDTH-1];
            CS      <= 1'b0;
            Busy    <= 1'b1;
            cnt_q   <= '0;
            edge_q  <= '0;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            state_q <= StShift;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StShift: begin
          if (cnt_q == CntLast) begin
            cnt_q  <= '0;
            SCK    <= ~SCK;
            edge_q <= edge_q + 1'b1;
            // edge_q counts completed edges, so an even value means a leading edge is due
            if (!edge_q[0]) begin
              if (!cpha_q) begin
                rx_q <= rx_next;
              end else begin
                SDO  <= tx_q[DATA_WIDTH-1];
                tx_q <= {tx_q[DATA_WIDTH-2:0], 1'b0};
              end
            end else begin
              if (cpha_q) begin
                rx_q <= rx_next;
              end else if (edge_q != EdgeLast) begin
                SDO  <= tx_q[DATA_WIDTH-2];
                tx_q <= {tx_q[DATA_WIDTH-2:0], 1'b0};
              end
            end
            if (edge_q == EdgeLast) begin
              state_q <= StHold;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHold: begin
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            CS      <= 1'b1;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            DataRd  <= rx_q;
            SDO     <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: a behavioural SPI slave plus directed and random transfers.
module tb_spi_master;

  localparam int DW = 8;
  localparam int CD = 4;
  localparam int BusyCycles = (2 * DW + 2) * CD;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          Start;
  logic [1:0]    Mode;
  logic [DW-1:0] DataWr;
  logic [DW-1:0] DataRd;
  logic          Busy;
  logic          Done;
  logic          SCK;
  logic          SDO;
  logic          SDI = 1'b0;
  logic          CS;
  logic          lsb_first = 1'b0;

  spi_master #(
    .DATA_WIDTH(DW),
    .CLK_DIV   (CD)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Start   (Start),
    .Mode    (Mode),
    .DataWr  (DataWr),
`ifdef SPIMASTER_LSBFIRST_EN
    .LsbFirst(lsb_first),
`endif
    .DataRd  (DataRd),
    .Busy    (Busy),
    .Done    (Done),
    .SCK     (SCK),
    .SDO     (SDO),
    .SDI     (SDI),
    .CS      (CS)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge Clk) cyc++;

  // Slave model: the mode decides which SCK edge shifts data out and which samples SDO.
  logic [1:0]    s_mode = 2'd0;
  logic [DW-1:0] s_reply = '0;
  logic [DW-1:0] s_rx = '0;
  int            s_edge = 0;
  int            rise_cnt = 0;
  int            cs_fall_cnt = 0;
  logic          cs_prev = 1'b1;

  always @(SCK or CS) begin
    int k;
    if (CS !== cs_prev) begin
      if (CS === 1'b0) begin
        s_edge = 0;
        s_rx   = '0;
        cs_fall_cnt++;
        if (!s_mode[0]) SDI = s_reply[DW-1];
      end
      cs_prev = CS;
    end else if (CS === 1'b0 && Rst_n === 1'b1) begin
      s_edge++;
      k = (s_edge - 1) / 2;
      if (SCK === 1'b1) rise_cnt++;
      if (s_edge % 2 == 1) begin
        if (!s_mode[0]) s_rx = {s_rx[DW-2:0], SDO};
        else SDI = s_reply[DW-1-k];
      end else begin
        if (s_mode[0]) s_rx = {s_rx[DW-2:0], SDO};
        else if (k < DW - 1) SDI = s_reply[DW-2-k];
      end
    end
  end

  function automatic logic [DW-1:0] rev(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = v[DW-1-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One full transfer; the bench expects the reply back and the slave to have seen DataWr.
  task automatic run_txn(input logic [1:0] m, input logic [DW-1:0] d, input logic [DW-1:0] r,
                         input bit lsb, input bit pulse, input bit scramble);
    int   busy;
    int   rise0;
    int   fall0;
    int   extra;
    logic got;
    @(negedge Clk);
    Mode = m; s_mode = m; s_reply = r; DataWr = d; lsb_first = lsb;
    @(negedge Clk);
    @(negedge Clk);
    chk("idle_sck_before", {31'd0, SCK}, {31'd0, m[1]});
    chk("idle_cs_before", {31'd0, CS}, 32'd1);
    rise0 = rise_cnt;
    fall0 = cs_fall_cnt;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    busy = 0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (Done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (Busy === 1'b1) busy++;
      Start = pulse && (i == 10 || i == 40);
      if (scramble && i == 20) begin
        Mode = 2'($urandom_range(0, 3));
        DataWr = 8'($urandom);
      end
      if (scramble && i == 30) Mode = m;
      @(negedge Clk);
    end
    Start = 1'b0;
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("busy_cycles", busy, BusyCycles);
    chk("data_rd", {24'd0, DataRd}, {24'd0, lsb ? rev(r) : r});
    chk("slave_rx", {24'd0, s_rx}, {24'd0, lsb ? rev(d) : d});
    chk("sck_rises", rise_cnt - rise0, DW);
    chk("cs_at_done", {31'd0, CS}, 32'd1);
    @(negedge Clk);
    chk("done_pulse_width", {31'd0, Done}, 32'd0);
    chk("idle_sck_after", {31'd0, SCK}, {31'd0, m[1]});
    if (pulse) begin
      extra = 0;
      repeat (100) begin
        @(negedge Clk);
        if (Done === 1'b1) extra++;
      end
      chk("pulse_extra_done", extra, 0);
      chk("pulse_cs_falls", cs_fall_cnt - fall0, 1);
    end
  endtask

  logic [DW-1:0] words[3]   = '{8'h01, 8'h80, 8'hFF};
  logic [DW-1:0] replies[3] = '{8'h3C, 8'h96, 8'h0F};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    rm;
    logic [DW-1:0] rd;
    logic [DW-1:0] rr;
    int            last_done;
    int            dn;
    logic          found;

    Rst_n = 1'b0; Start = 1'b0; Mode = 2'd0; DataWr = '0;
    #12;
    chk("rst_cs", {31'd0, CS}, 32'd1);
    chk("rst_sck", {31'd0, SCK}, 32'd0);
    chk("rst_sdo", {31'd0, SDO}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_datard", {24'd0, DataRd}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    run_txn(2'd0, 8'hA5, 8'hAA, 1'b0, 1'b0, 1'b0);
    run_txn(2'd1, 8'h3B, 8'h72, 1'b0, 1'b0, 1'b0);
    run_txn(2'd2, 8'hE4, 8'hC3, 1'b0, 1'b0, 1'b0);
    run_txn(2'd3, 8'h19, 8'h5D, 1'b0, 1'b0, 1'b0);

    run_txn(2'd0, 8'h6E, 8'h81, 1'b0, 1'b1, 1'b0);

    // Start held high across three words
    @(negedge Clk);
    Mode = 2'd0; s_mode = 2'd0; DataWr = words[0]; s_reply = replies[0]; Start = 1'b1;
    last_done = 0;
    for (int w = 0; w < 3; w++) begin
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge Clk);
        if (Done === 1'b1) begin
          found = 1'b1;
          break;
        end
      end
      chk("b2b_done_seen", {31'd0, found}, 32'd1);
      chk("b2b_data_rd", {24'd0, DataRd}, {24'd0, replies[w]});
      chk("b2b_slave_rx", {24'd0, s_rx}, {24'd0, words[w]});
      if (w > 0) chk("b2b_done_spacing", cyc - last_done, BusyCycles + 1);
      last_done = cyc;
      chk("b2b_cs_gap_high", {31'd0, CS}, 32'd1);
      if (w < 2) begin
        DataWr = words[w+1];
        s_reply = replies[w+1];
      end else begin
        Start = 1'b0;
      end
      @(negedge Clk);
      chk("b2b_cs_after_gap", {31'd0, CS}, (w < 2) ? 32'd0 : 32'd1);
    end

    // Asynchronous abort part-way through a word
    @(negedge Clk);
    Mode = 2'd0; s_mode = 2'd0; DataWr = 8'h3C; s_reply = 8'h99; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (29) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    chk("abort_cs", {31'd0, CS}, 32'd1);
    chk("abort_sck", {31'd0, SCK}, 32'd0);
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    dn = 0;
    repeat (5) begin
      @(negedge Clk);
      if (Done === 1'b1) dn++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_datard", {24'd0, DataRd}, 32'd0);
    Rst_n = 1'b1;
    run_txn(2'd0, 8'h5A, 8'h24, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      rm = 2'($urandom_range(0, 3));
      rd = 8'($urandom);
      rr = 8'($urandom);
      run_txn(rm, rd, rr, 1'b0, 1'b0, 1'b1);
    end

`ifdef SPIMASTER_LSBFIRST_EN
    run_txn(2'd0, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0);
    run_txn(2'd3, 8'hB2, 8'h4D, 1'b1, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
